// File: rtl/input_debounce_pkg.sv
// Shared constants and helpers for the GPIO input debouncer.
package input_debounce_pkg;

    localparam int unsigned DebounceMsDefault = 5;

    localparam int unsigned GpInSelWidth      = 3;
    localparam int unsigned GpInNavWidth      = 5;
    localparam int unsigned GpInUserWidth     = 8;
    localparam int unsigned GpInDebounceWidth = GpInSelWidth + GpInNavWidth + GpInUserWidth;

    // Clock cycles per 1 ms debounce tick.
    function automatic int unsigned tick_period(input int unsigned clk_freq);
        return clk_freq / 1000;
    endfunction

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/input_debounce_if.sv
// Pin-side and status signals of the input debouncer; slave is the debouncer side.
interface input_debounce_if #(
    parameter int unsigned Width = 16
);

    logic [Width-1:0] raw_i;
    logic [Width-1:0] clr_i;
    logic [Width-1:0] irq_en_i;
    logic [Width-1:0] stable_o;
    logic [Width-1:0] changed_o;
    logic [Width-1:0] rise_o;
    logic [Width-1:0] fall_o;
    logic             irq_o;

    modport master (
        output raw_i, clr_i, irq_en_i,
        input  stable_o, changed_o, rise_o, fall_o, irq_o
    );

    modport slave (
        input  raw_i, clr_i, irq_en_i,
        output stable_o, changed_o, rise_o, fall_o, irq_o
    );

endinterface

// File: rtl/input_debounce_cell.sv
// debounce_cell: one bit's 2-flop synchroniser, tick-driven persistence counter and stable flop.
module input_debounce_cell
    import input_debounce_pkg::*;
#(
    parameter int unsigned DebounceMs = DebounceMsDefault,
    parameter bit          ResetValue = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    input  logic tick_i,
    output logic stable_o,
    output logic update_o
);

    localparam int unsigned    CntW   = $clog2(DebounceMs + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceMs - 1);

    logic            sync1_q, sync_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q  <= ResetValue;
            sync_q   <= ResetValue;
            stable_q <= ResetValue;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync_q   <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        update_o = 1'b0;
        // Any return to the stable level restarts the persistence count.
        if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CntMax) begin
                stable_d = sync_q;
                cnt_d    = '0;
                update_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/input_debounce.sv
// Debounces board inputs with sticky change flags and a maskable irq.
// Define INPUT_DEBOUNCE_EDGE_EN to build registered rise_o/fall_o pulses; otherwise they are 0.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int unsigned      Width      = GpInDebounceWidth,
    parameter int unsigned      SysClkFreq = 40_000_000,
    parameter int unsigned      DebounceMs = DebounceMsDefault,
    parameter logic [Width-1:0] ResetValue = '1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input_debounce_if.slave   bus_io
);

    localparam int unsigned     TickPeriod = tick_period(SysClkFreq);
    localparam int unsigned     PreW       = cnt_width(TickPeriod);
    localparam logic [PreW-1:0] PreMax     = PreW'(TickPeriod - 1);

    if (DebounceMs < 1) begin : g_chk_debounce
        $error("DebounceMs must be >= 1");
    end
    if (SysClkFreq < 1000) begin : g_chk_freq
        $error("SysClkFreq must be >= 1000");
    end
    if (Width < 1) begin : g_chk_width
        $error("Width must be >= 1");
    end

    logic [PreW-1:0]  presc_q, presc_d;
    logic             tick;
    logic [Width-1:0] stable;
    logic [Width-1:0] update;
    logic [Width-1:0] changed_q, changed_d;
    logic             irq_q, irq_d;

    // Shared 1 ms prescaler.
    assign tick    = (presc_q == PreMax);
    assign presc_d = tick ? '0 : presc_q + PreW'(1);

    for (genvar i = 0; i < Width; i++) begin : g_cell
        input_debounce_cell #(
            .DebounceMs (DebounceMs),
            .ResetValue (ResetValue[i])
        ) u_cell (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .raw_i    (bus_io.raw_i[i]),
            .tick_i   (tick),
            .stable_o (stable[i]),
            .update_o (update[i])
        );
    end

    // A new change beats a simultaneous clear.
    assign changed_d = update | (changed_q & ~bus_io.clr_i);
    assign irq_d     = |(changed_q & bus_io.irq_en_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q   <= '0;
            changed_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            changed_q <= changed_d;
            irq_q     <= irq_d;
        end
    end

    assign bus_io.stable_o  = stable;
    assign bus_io.changed_o = changed_q;
    assign bus_io.irq_o     = irq_q;

`ifdef INPUT_DEBOUNCE_EDGE_EN
    logic [Width-1:0] rise_q, fall_q;

    // stable still holds the old level in the update cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= update & ~stable;
            fall_q <= update & stable;
        end
    end

    assign bus_io.rise_o = rise_q;
    assign bus_io.fall_o = fall_q;
`else
    assign bus_io.rise_o = '0;
    assign bus_io.fall_o = '0;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: T=10 cycles, DebounceMs=3, Width=4.
module tb_input_debounce;

    localparam int unsigned W = 4;
`ifdef INPUT_DEBOUNCE_EDGE_EN
    localparam logic EdgeEn = 1'b1;
`else
    localparam logic EdgeEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   n_checks = 0;
    int   lat;

    input_debounce_if #(.Width(W)) bus ();

    input_debounce #(
        .Width      (W),
        .SysClkFreq (10_000),
        .DebounceMs (3),
        .ResetValue (4'hF)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Steps until stable_o[idx] == val, bounded to 60 cycles.
    task automatic wait_bit(input int idx, input logic val, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (bus.stable_o[idx] !== val && n < 60);
    endtask

    initial begin
        rst          = 1'b1;
        bus.raw_i    = 4'b0000;
        bus.clr_i    = 4'b0000;
        bus.irq_en_i = 4'b0000;
        step(3);
        check("rst_stable", 32'(bus.stable_o), 32'hF);
        check("rst_changed", 32'(bus.changed_o), 32'h0);
        check("rst_irq", 32'(bus.irq_o), 32'h0);
        check("rst_rise", 32'(bus.rise_o), 32'h0);
        check("rst_fall", 32'(bus.fall_o), 32'h0);

        rst       = 1'b0;
        bus.raw_i = 4'b1111;
        step(40);
        check("post_rst_stable", 32'(bus.stable_o), 32'hF);
        check("post_rst_changed", 32'(bus.changed_o), 32'h0);

        // Clean falling edge on bit 0
        bus.raw_i = 4'b1110;
        wait_bit(0, 1'b0, lat);
        check("clean_lat_22_32", 32'(lat >= 22 && lat <= 32), 32'h1);
        check("clean_stable", 32'(bus.stable_o), 32'hE);
        check("clean_changed", 32'(bus.changed_o), 32'h1);
        check("clean_fall", 32'(bus.fall_o), 32'(EdgeEn));
        check("clean_rise", 32'(bus.rise_o), 32'h0);
        step(1);
        check("clean_fall_end", 32'(bus.fall_o), 32'h0);
        check("clean_irq_masked", 32'(bus.irq_o), 32'h0);
        bus.clr_i = 4'b0001;
        step(1);
        bus.clr_i = 4'b0000;
        check("clean_clr", 32'(bus.changed_o), 32'h0);

        // Glitch on bit 1 shorter than three ticks
        bus.raw_i = 4'b1100;
        step(15);
        bus.raw_i = 4'b1110;
        step(40);
        check("glitch_stable", 32'(bus.stable_o), 32'hE);
        check("glitch_changed", 32'(bus.changed_o), 32'h0);

        // Set and clear of changed_o[2] in the same cycle
        bus.clr_i = 4'b0100;
        bus.raw_i = 4'b1010;
        wait_bit(2, 1'b0, lat);
        check("race_lat_22_32", 32'(lat >= 22 && lat <= 32), 32'h1);
        check("race_set_wins", 32'(bus.changed_o), 32'h4);
        bus.clr_i = 4'b0000;
        step(3);
        check("race_sticky", 32'(bus.changed_o), 32'h4);
        bus.clr_i = 4'b0100;
        step(1);
        bus.clr_i = 4'b0000;
        check("race_clr", 32'(bus.changed_o), 32'h0);
        check("race_stable", 32'(bus.stable_o), 32'hA);

        // Interrupt masking on bit 3
        bus.irq_en_i = 4'b0001;
        bus.raw_i    = 4'b0010;
        wait_bit(3, 1'b0, lat);
        step(2);
        check("irq_changed3", 32'(bus.changed_o), 32'h8);
        check("irq_masked", 32'(bus.irq_o), 32'h0);
        bus.irq_en_i = 4'b1000;
        step(1);
        check("irq_enabled", 32'(bus.irq_o), 32'h1);
        bus.clr_i = 4'b1000;
        step(1);
        bus.clr_i = 4'b0000;
        check("irq_clr_changed", 32'(bus.changed_o), 32'h0);
        check("irq_lag", 32'(bus.irq_o), 32'h1);
        step(1);
        check("irq_drop", 32'(bus.irq_o), 32'h0);

        // Rising edge on bit 0 with its interrupt enabled
        bus.irq_en_i = 4'b0001;
        bus.raw_i    = 4'b0011;
        wait_bit(0, 1'b1, lat);
        check("rise_lat_22_32", 32'(lat >= 22 && lat <= 32), 32'h1);
        check("rise_pulse", 32'(bus.rise_o), 32'(EdgeEn));
        check("rise_no_fall", 32'(bus.fall_o), 32'h0);
        check("rise_changed", 32'(bus.changed_o), 32'h1);
        check("rise_irq_pre", 32'(bus.irq_o), 32'h0);
        step(1);
        check("rise_irq", 32'(bus.irq_o), 32'h1);
        check("rise_pulse_end", 32'(bus.rise_o), 32'h0);

        // Asynchronous reset with bit 1 two ticks into its debounce
        bus.raw_i = 4'b0001;
        step(22);
        check("pend_stable", 32'(bus.stable_o), 32'h3);
        rst = 1'b1;
        #2;
        check("async_stable", 32'(bus.stable_o), 32'hF);
        check("async_changed", 32'(bus.changed_o), 32'h0);
        check("async_irq", 32'(bus.irq_o), 32'h0);
        step(2);
        bus.raw_i = 4'b1101;
        rst       = 1'b0;
        wait_bit(1, 1'b0, lat);
        check("rerun_lat_22_32", 32'(lat >= 22 && lat <= 32), 32'h1);
        check("rerun_stable", 32'(bus.stable_o), 32'hD);
        check("rerun_changed", 32'(bus.changed_o), 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
